// File: rtl/polirv_boot_ctrl_if.sv
// Program-load stream between the host loader and the polirv boot controller.
// The master drives words in; the slave (controller) accepts them with load_ready.
interface polirv_boot_ctrl_if #(
   parameter int I_DATA_W = 32
);
   logic                load_valid;
   logic                load_ready;
   logic [I_DATA_W-1:0] load_data;
   logic                load_last;

   modport master (output load_valid, load_data, load_last, input load_ready);
   modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/polirv_boot_ctrl.sv
// Boot-and-run controller: streams a program into instruction memory with the core held
// in reset, then releases the core and counts run cycles until a halt fetch or a timeout.
module polirv_boot_ctrl #(
   parameter int                  I_ADDR_W   = 6,
   parameter int                  I_DATA_W   = 32,
   parameter logic [31:0]         MAX_CYCLES = 32'd125,
   parameter logic [I_DATA_W-1:0] HALT_WORD  = 'h0000006F
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   polirv_boot_ctrl_if.slave     load_if,
   output logic                  imem_we_o,
   output logic [I_ADDR_W-1:0]   imem_waddr_o,
   output logic [I_DATA_W-1:0]   imem_wdata_o,
   output logic                  core_reset_o,
   input  logic [I_ADDR_W-1:0]   i_mem_addr_i,
   input  logic [I_DATA_W-1:0]   i_mem_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  halted_o,
   output logic                  timeout_o,
   output logic [31:0]           cycle_count_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [I_ADDR_W-1:0] ptr_q, ptr_d;
   logic                core_reset_q, core_reset_d;
   logic                halted_q, halted_d;
   logic                timeout_q, timeout_d;
   logic [31:0]         cycle_count_q, cycle_count_d;
   logic                xfer;
   logic                ptr_full;

   // The fetch address is only observed by the host; halt detection keys on fetched data.
   logic                fetch_addr_unused;
   assign fetch_addr_unused = ^i_mem_addr_i;

   assign ptr_full = (ptr_q == {I_ADDR_W{1'b1}});

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      core_reset_d  = core_reset_q;
      halted_d      = halted_q;
      timeout_d     = timeout_q;
      cycle_count_d = cycle_count_q;
      xfer          = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d       = LOAD;
               ptr_d         = '0;
               halted_d      = 1'b0;
               timeout_d     = 1'b0;
               cycle_count_d = 32'd0;
            end
         end
         LOAD: begin
            xfer = load_if.load_valid;
            if (xfer) begin
               // The pointer saturates at the last word; a full memory ends the load.
               if (!ptr_full) begin
                  ptr_d = ptr_q + 1'b1;
               end
               if (load_if.load_last || ptr_full) begin
                  state_d      = RUN;
                  core_reset_d = 1'b0;
               end
            end
         end
         RUN: begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (i_mem_data_i == HALT_WORD) begin
               state_d      = DONE;
               halted_d     = 1'b1;
               core_reset_d = 1'b1;
            end else if (cycle_count_q == (MAX_CYCLES - 32'd1)) begin
               state_d      = DONE;
               timeout_d    = 1'b1;
               core_reset_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         core_reset_q  <= 1'b1;
         halted_q      <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         core_reset_q  <= core_reset_d;
         halted_q      <= halted_d;
         timeout_q     <= timeout_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Writes happen in the same cycle as the handshake so the loader sees no latency.
   assign load_if.load_ready = (state_q == LOAD);
   assign imem_we_o          = xfer;
   assign imem_waddr_o       = ptr_q;
   assign imem_wdata_o       = load_if.load_data;

   assign core_reset_o  = core_reset_q;
   assign busy_o        = (state_q == LOAD) || (state_q == RUN);
   assign done_o        = (state_q == DONE);
   assign halted_o      = halted_q;
   assign timeout_o     = timeout_q;
   assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_polirv_boot_ctrl.sv
// Self-checking bench for polirv_boot_ctrl: a default-sized instance with a stub core,
// and a small instance (4-word memory, 10-cycle limit) for depth and timeout corners.
module tb_polirv_boot_ctrl;

   localparam logic [31:0] W0   = 32'h00500093;
   localparam logic [31:0] W1   = 32'h00A00113;
   localparam logic [31:0] W2   = 32'h002081B3;
   localparam logic [31:0] W3   = 32'h0000006F;
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] BAD  = 32'hDEADBEEF;
   localparam logic [31:0] HALT = 32'h0000006F;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   // Instance A: default parameters, driven by a stub core fetching from a bench memory
   logic        rstA;
   logic        startA;
   logic        weA;
   logic [5:0]  waddrA;
   logic [31:0] wdataA;
   logic        coreResetA;
   logic [5:0]  fetchAddrA;
   logic [31:0] fetchDataA;
   logic        busyA, doneA, haltedA, timeoutA;
   logic [31:0] ccA;
   logic [31:0] memA [64];
   int          weCountA = 0;

   polirv_boot_ctrl_if #(.I_DATA_W(32)) ifA ();

   polirv_boot_ctrl dutA (
      .clk          (clk),
      .reset        (rstA),
      .start_i      (startA),
      .load_if      (ifA),
      .imem_we_o    (weA),
      .imem_waddr_o (waddrA),
      .imem_wdata_o (wdataA),
      .core_reset_o (coreResetA),
      .i_mem_addr_i (fetchAddrA),
      .i_mem_data_i (fetchDataA),
      .busy_o       (busyA),
      .done_o       (doneA),
      .halted_o     (haltedA),
      .timeout_o    (timeoutA),
      .cycle_count_o(ccA)
   );

   // Instance B: 4-word memory and a 10-cycle limit; fetched data driven directly
   logic        rstB;
   logic        startB;
   logic        weB;
   logic [1:0]  waddrB;
   logic [31:0] wdataB;
   logic        coreResetB;
   logic [1:0]  fetchAddrB;
   logic [31:0] fetchDataB;
   logic        busyB, doneB, haltedB, timeoutB;
   logic [31:0] ccB;

   polirv_boot_ctrl_if #(.I_DATA_W(32)) ifB ();

   polirv_boot_ctrl #(.I_ADDR_W(2), .MAX_CYCLES(32'd10)) dutB (
      .clk          (clk),
      .reset        (rstB),
      .start_i      (startB),
      .load_if      (ifB),
      .imem_we_o    (weB),
      .imem_waddr_o (waddrB),
      .imem_wdata_o (wdataB),
      .core_reset_o (coreResetB),
      .i_mem_addr_i (fetchAddrB),
      .i_mem_data_i (fetchDataB),
      .busy_o       (busyB),
      .done_o       (doneB),
      .halted_o     (haltedB),
      .timeout_o    (timeoutB),
      .cycle_count_o(ccB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side instruction memory written by the controller, and a stub core that
   // restarts its fetch at word 0 whenever it is held in reset
   always @(posedge clk) begin
      if (weA) begin
         memA[waddrA] <= wdataA;
         weCountA     <= weCountA + 1;
      end
      if (coreResetA) fetchAddrA <= 6'd0;
      else            fetchAddrA <= fetchAddrA + 6'd1;
   end
   assign fetchDataA = memA[fetchAddrA];
   assign fetchAddrB = 2'd0;

   typedef struct {
      logic        start;
      logic        valid;
      logic        last;
      logic [31:0] data;
      logic        expReady;
      logic        expWe;
      logic [5:0]  expWaddr;
      logic [31:0] expWdata;
      logic        expCoreReset;
      logic        expBusy;
      logic        expDone;
      logic [31:0] expCc;
   } vecT;

   vecT vecs [11];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vecT v);
      startA         = v.start;
      ifA.load_valid = v.valid;
      ifA.load_last  = v.last;
      ifA.load_data  = v.data;
   endtask

   // Loads four words into instance A, checking each write; returns at the first RUN negedge
   task automatic loadA(input logic [3:0][31:0] prog);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ifA.load_valid = 1'b1;
         ifA.load_data  = prog[i];
         ifA.load_last  = (i == 3);
         #1;
         checkOutput($sformatf("loadA.we%0d", i), 32'(weA), 32'd1);
         checkOutput($sformatf("loadA.waddr%0d", i), 32'(waddrA), 32'(i));
         checkOutput($sformatf("loadA.wdata%0d", i), wdataA, prog[i]);
      end
      @(negedge clk);
      ifA.load_valid = 1'b0;
      ifA.load_last  = 1'b0;
      #1;
   endtask

   initial begin
      int weBase;
      int runCount;

      for (int i = 0; i < 64; i++) memA[i] = 32'd0;

      //                start valid last data | ready we waddr wdata | coreRst busy done cc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, W0,    1'b1, 1'b1, 6'd0, W0,    1'b1, 1'b1, 1'b0, 32'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, W1,    1'b1, 1'b1, 6'd1, W1,    1'b1, 1'b1, 1'b0, 32'd0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, BAD,   1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, W2,    1'b1, 1'b1, 6'd2, W2,    1'b1, 1'b1, 1'b0, 32'd0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, W3,    1'b1, 1'b1, 6'd3, W3,    1'b1, 1'b1, 1'b0, 32'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, BAD,   1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, BAD,   1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd2};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd3};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd4};

      startA = 1'b0; ifA.load_valid = 1'b0; ifA.load_last = 1'b0; ifA.load_data = 32'd0;
      startB = 1'b0; ifB.load_valid = 1'b0; ifB.load_last = 1'b0; ifB.load_data = 32'd0;
      fetchDataB = 32'd0;
      rstA = 1'b1; rstB = 1'b1;
      #1;
      rstA = 1'b0; rstB = 1'b0;

      // Reset held with start and load_valid asserted must keep everything quiet
      startA = 1'b1; ifA.load_valid = 1'b1; ifA.load_data = BAD;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checkOutput($sformatf("rst%0d.coreReset", c), 32'(coreResetA), 32'd1);
         checkOutput($sformatf("rst%0d.ready", c), 32'(ifA.load_ready), 32'd0);
         checkOutput($sformatf("rst%0d.busy", c), 32'(busyA), 32'd0);
         checkOutput($sformatf("rst%0d.done", c), 32'(doneA), 32'd0);
         checkOutput($sformatf("rst%0d.cc", c), ccA, 32'd0);
         checkOutput($sformatf("rst%0d.we", c), 32'(weA), 32'd0);
      end
      checkOutput("rst.weCount", 32'(weCountA), 32'd0);
      startA = 1'b0; ifA.load_valid = 1'b0;
      @(negedge clk);
      rstA = 1'b1; rstB = 1'b1;

      // Table-driven load with a gap, then a stub-core run ending on the halt word
      weBase = weCountA;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d.ready", i), 32'(ifA.load_ready), 32'(vecs[i].expReady));
         checkOutput($sformatf("v%0d.we", i), 32'(weA), 32'(vecs[i].expWe));
         if (vecs[i].expWe) begin
            checkOutput($sformatf("v%0d.waddr", i), 32'(waddrA), 32'(vecs[i].expWaddr));
            checkOutput($sformatf("v%0d.wdata", i), wdataA, vecs[i].expWdata);
         end
         checkOutput($sformatf("v%0d.coreReset", i), 32'(coreResetA), 32'(vecs[i].expCoreReset));
         checkOutput($sformatf("v%0d.busy", i), 32'(busyA), 32'(vecs[i].expBusy));
         checkOutput($sformatf("v%0d.done", i), 32'(doneA), 32'(vecs[i].expDone));
         checkOutput($sformatf("v%0d.cc", i), ccA, vecs[i].expCc);
      end
      checkOutput("halt.halted", 32'(haltedA), 32'd1);
      checkOutput("halt.timeout", 32'(timeoutA), 32'd0);
      checkOutput("load.weCount", 32'(weCountA - weBase), 32'd4);

      // Restart from DONE clears status; start during RUN is ignored; reset mid-run
      @(negedge clk); startA = 1'b1;
      @(negedge clk); startA = 1'b0; #1;
      checkOutput("restart.busy", 32'(busyA), 32'd1);
      checkOutput("restart.done", 32'(doneA), 32'd0);
      checkOutput("restart.halted", 32'(haltedA), 32'd0);
      checkOutput("restart.cc", ccA, 32'd0);
      loadA({NOP, W2, W1, W0});
      checkOutput("run2.coreReset", 32'(coreResetA), 32'd0);
      checkOutput("run2.cc0", ccA, 32'd0);
      startA = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         startA = 1'b0;
         #1;
         checkOutput($sformatf("run2.cc%0d", k), ccA, 32'(k));
         checkOutput($sformatf("run2.busy%0d", k), 32'(busyA), 32'd1);
      end
      rstA = 1'b0;
      #1;
      checkOutput("midRst.coreReset", 32'(coreResetA), 32'd1);
      checkOutput("midRst.cc", ccA, 32'd0);
      checkOutput("midRst.busy", 32'(busyA), 32'd0);
      checkOutput("midRst.ready", 32'(ifA.load_ready), 32'd0);
      checkOutput("midRst.done", 32'(doneA), 32'd0);
      @(negedge clk); rstA = 1'b1;
      @(negedge clk); startA = 1'b1;
      @(negedge clk); startA = 1'b0;
      loadA({W3, W2, W1, W0});
      for (int k = 0; k < 50 && !doneA; k++) @(negedge clk);
      #1;
      checkOutput("rerun.done", 32'(doneA), 32'd1);
      checkOutput("rerun.halted", 32'(haltedA), 32'd1);
      checkOutput("rerun.timeout", 32'(timeoutA), 32'd0);
      checkOutput("rerun.cc", ccA, 32'd4);
      checkOutput("rerun.coreReset", 32'(coreResetA), 32'd1);

      // Instance B: fill all four words without load_last, then run into the cycle limit
      @(negedge clk); startB = 1'b1;
      @(negedge clk); startB = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         ifB.load_valid = 1'b1;
         ifB.load_data  = 32'h11110000 + 32'(i);
         ifB.load_last  = 1'b0;
         #1;
         checkOutput($sformatf("full.we%0d", i), 32'(weB), 32'd1);
         checkOutput($sformatf("full.waddr%0d", i), 32'(waddrB), 32'(i));
         checkOutput($sformatf("full.wdata%0d", i), wdataB, 32'h11110000 + 32'(i));
      end
      @(negedge clk);
      ifB.load_data = BAD;
      #1;
      checkOutput("full.fifthReady", 32'(ifB.load_ready), 32'd0);
      checkOutput("full.fifthWe", 32'(weB), 32'd0);
      checkOutput("full.coreReset", 32'(coreResetB), 32'd0);
      checkOutput("full.busy", 32'(busyB), 32'd1);
      ifB.load_valid = 1'b0;
      runCount = 1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk); #1;
         if (doneB) break;
         if (!coreResetB) runCount++;
      end
      checkOutput("tmo.done", 32'(doneB), 32'd1);
      checkOutput("tmo.timeout", 32'(timeoutB), 32'd1);
      checkOutput("tmo.halted", 32'(haltedB), 32'd0);
      checkOutput("tmo.cc", ccB, 32'd10);
      checkOutput("tmo.runCycles", 32'(runCount), 32'd10);
      checkOutput("tmo.coreReset", 32'(coreResetB), 32'd1);

      // Halt fetched on the same edge the limit is reached: halt wins
      @(negedge clk); startB = 1'b1;
      @(negedge clk); startB = 1'b0;
      ifB.load_valid = 1'b1; ifB.load_data = NOP; ifB.load_last = 1'b1;
      #1;
      checkOutput("hl.timeoutCleared", 32'(timeoutB), 32'd0);
      checkOutput("hl.we", 32'(weB), 32'd1);
      checkOutput("hl.waddr", 32'(waddrB), 32'd0);
      @(negedge clk);
      ifB.load_valid = 1'b0; ifB.load_last = 1'b0;
      for (int k = 0; k < 20 && ccB != 32'd9; k++) @(negedge clk);
      checkOutput("hl.reach9", ccB, 32'd9);
      fetchDataB = HALT;
      @(negedge clk); #1;
      fetchDataB = 32'd0;
      checkOutput("hl.done", 32'(doneB), 32'd1);
      checkOutput("hl.halted", 32'(haltedB), 32'd1);
      checkOutput("hl.timeout", 32'(timeoutB), 32'd0);
      checkOutput("hl.cc", ccB, 32'd10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
